// File: rtl/uart_rx.sv
// 16x-oversampled asynchronous serial receiver: start, DATA_BITS data (LSB first),
// optional parity, one stop bit, delivered through an rxrdy/read holding register.
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic       mclkx16,
    input  logic       reset,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data,
    output logic       rxrdy,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_LOAD,
        S_BREAK
    } state_t;

    localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [3:0]           r_tick;
    logic [3:0]           w_tick_next;
    logic [2:0]           r_index;
    logic [2:0]           w_index_next;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_bit;
    logic                 w_sample_data;
    logic                 w_sample_par;
    logic                 w_sample_stop;
    logic                 w_load;
    logic [7:0]           w_byte;
    logic                 w_ones_odd;
    logic                 w_parity_err;

    always_ff @(posedge mclkx16) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_index <= '0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_index <= w_index_next;
        end
    end

    // Tick free-runs (wrapping 15->0) except where a state explicitly restarts it.
    always_comb begin
        w_state_next  = r_state;
        w_tick_next   = r_tick + 4'd1;
        w_index_next  = r_index;
        w_sample_data = 1'b0;
        w_sample_par  = 1'b0;
        w_sample_stop = 1'b0;
        w_load        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tick_next = '0;
                if (!r_rx_s) w_state_next = S_START;
            end
            S_START: begin
                if (r_tick == 4'd7) begin
                    w_tick_next  = '0;
                    w_index_next = '0;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_tick == 4'd15) begin
                    w_sample_data = 1'b1;
                    if (r_index == LAST_INDEX) begin
                        w_index_next = '0;
                        w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_index_next = r_index + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (r_tick == 4'd15) begin
                    w_sample_par = 1'b1;
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (r_tick == 4'd15) begin
                    w_sample_stop = 1'b1;
                    w_state_next  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load       = 1'b1;
                w_tick_next  = '0;
                w_state_next = r_stop_bit ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                w_tick_next = '0;
                if (r_rx_s) w_state_next = S_IDLE;
            end
            default: begin
                w_tick_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge mclkx16) begin
        if (!reset) begin
            r_rx_meta  <= 1'b1;
            r_rx_s     <= 1'b1;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            if (w_sample_par)  r_par_bit  <= r_rx_s;
            if (w_sample_stop) r_stop_bit <= r_rx_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            always_ff @(posedge mclkx16) begin
                if (!reset) begin
                    r_shift[gi] <= 1'b0;
                end else if (w_sample_data && (r_index == 3'(gi))) begin
                    r_shift[gi] <= r_rx_s;
                end
            end
        end
        for (gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < DATA_BITS) begin : g_used
                assign w_byte[gi] = r_shift[gi];
            end else begin : g_unused
                assign w_byte[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_ones_odd   = ^{r_shift, r_par_bit};
    assign w_parity_err = (PARITY == 1) ? w_ones_odd :
                          (PARITY == 2) ? ~w_ones_odd : 1'b0;

    // A load in the same cycle as a read wins; the read only suppresses overrun.
    always_ff @(posedge mclkx16) begin
        if (!reset) begin
            data          <= '0;
            rxrdy         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else if (w_load) begin
            data          <= w_byte;
            rxrdy         <= 1'b1;
            parity_error  <= w_parity_err;
            framing_error <= ~r_stop_bit;
            overrun       <= rxrdy & ~read;
        end else if (read && rxrdy) begin
            rxrdy         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end
    end

endmodule
